// File: rtl/bit_serial_adder_pkg.sv
// rtl/bit_serial_adder_pkg.sv - shared state type and width default for the bit-serial adder
package bit_serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serial_adder_if.sv
// rtl/bit_serial_adder_if.sv - operand/result bundle; ovf present only with BIT_SERIAL_ADDER_OVF_EN
interface bit_serial_adder_if #(
  parameter int WIDTH = bit_serial_adder_pkg::WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (output start, a, b, c_in, input busy, done, sum, c_out, ovf);
  modport slave  (input start, a, b, c_in, output busy, done, sum, c_out, ovf);
`else
  modport master (output start, a, b, c_in, input busy, done, sum, c_out);
  modport slave  (input start, a, b, c_in, output busy, done, sum, c_out);
`endif

endinterface

// File: rtl/bit_serial_adder_fa_cell.sv
// rtl/bit_serial_adder_fa_cell.sv - one-bit combinational full adder used once per serial step
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - LSB-first serial adder, one bit per clock; BIT_SERIAL_ADDER_OVF_EN adds ovf
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  bit_serial_adder_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_q;
  logic             c_out_q;
  logic             busy_q;
  logic             done_q;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  fa_cell u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Shift-then-overwrite keeps this legal for WIDTH=1, where no upper slice exists.
  always_comb begin
    sum_d           = sum_q >> 1;
    sum_d[WIDTH-1]  = fa_s;
    last_bit        = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.c_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= sum_d;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            c_out_q <= fa_co;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            // carry_q here is the carry into the MSB, fa_co the carry out of it
            ovf_q   <= fa_co ^ carry_q;
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - randomized scoreboard bench for bit_serial_adder (WIDTH=8)
module tb_bit_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W:0] val;
    logic       ovf;
    int         acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_acc = 0;
  int   last_done = -1;
  bit   b2b_en = 1'b0;
  logic [W:0] last_val = '0;
  exp_t sb_q[$];

  bit_serial_adder_if #(.WIDTH(W)) bus ();

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    exp_t e;
    int   sa, sb, s;
    e.val = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    s  = sa + sb + int'(ci);
    e.ovf = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy=%0b required 0", bus.busy);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    exp_t e;
    wait_idle();
    bus.a = a;
    bus.b = b;
    bus.c_in = ci;
    bus.start = 1'b1;
    e = model(a, b, ci);
    e.acc_cyc = cyc + 1;
    last_acc = e.acc_cyc;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.c_in = 1'(($urandom));
  endtask

  // Monitor: pops expectations on each done and checks results are held while idle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_val = '0;
      end else if (bus.done) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done sum=%h c_out=%0b required no done", bus.sum, bus.c_out);
        end else begin
          e = sb_q.pop_front();
          if ({bus.c_out, bus.sum} !== e.val) begin
            errors++;
            $display("FAIL result got=%h required=%h", {bus.c_out, bus.sum}, e.val);
          end
          checks++;
          if (cyc - e.acc_cyc != W) begin
            errors++;
            $display("FAIL latency got=%0d required=%0d", cyc - e.acc_cyc, W);
          end
`ifdef BIT_SERIAL_ADDER_OVF_EN
          checks++;
          if (bus.ovf !== e.ovf) begin
            errors++;
            $display("FAIL ovf got=%0b required=%0b", bus.ovf, e.ovf);
          end
`endif
          if (b2b_en && last_done >= 0) begin
            checks++;
            if (cyc - last_done != W + 2) begin
              errors++;
              $display("FAIL spacing got=%0d required=%0d", cyc - last_done, W + 2);
            end
          end
          last_val = e.val;
        end
        last_done = cyc;
      end else if (!bus.busy) begin
        checks++;
        if ({bus.c_out, bus.sum} !== last_val) begin
          errors++;
          $display("FAIL hold got=%h required=%h", {bus.c_out, bus.sum}, last_val);
        end
      end
    end
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.c_out, bus.sum} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h required=0", {bus.busy, bus.done, bus.c_out, bus.sum});
    end
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'h00, 8'h00, 1'b0);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_shift got=%0b required=1", bus.busy);
    end
    issue(8'hFF, 8'h01, 1'b0);
    issue(8'hA5, 8'h5A, 1'b1);
    issue(8'h3C, 8'h0F, 1'b1);
    issue(8'h7F, 8'h01, 1'b0);
    issue(8'h80, 8'hFF, 1'b0);
    issue(8'h10, 8'h20, 1'b0);

    // Stray starts during SHIFT and DONE must be ignored.
    issue(8'h3C, 8'h0F, 1'b1);
    while (cyc < last_acc + 2) @(negedge clk);
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'h11;
    while (cyc < last_acc + W) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of an operation.
    issue(8'h55, 8'h66, 1'b0);
    while (cyc < last_acc + 3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.c_out, bus.sum} !== '0) begin
      errors++;
      $display("FAIL mid_reset got=%h required=0", {bus.busy, bus.done, bus.c_out, bus.sum});
    end
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'h12, 8'h34, 1'b0);

    wait_idle();
    b2b_en = 1'b1;
    last_done = -1;
    for (int i = 0; i < 300; i++)
      issue(W'($urandom), W'($urandom), 1'(($urandom)));
    issue(8'hFF, 8'hFF, 1'b1);
    issue(8'h00, 8'h00, 1'b1);

    n = 0;
    while ((sb_q.size() != 0 || bus.busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", sb_q.size());
    end
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
